// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline register with bubble squash and flush; define PIPE_SKID_EN for a two-entry skid buffer.
// One cycle latency; single-entry in_ready = ~out_valid | out_ready, skid build in_ready = ~skid_valid (registered).
module pipe_stage_reg #(
  parameter int                CTRL_W         = 16,
  parameter int                DATA_W         = 128,
  parameter int                PC_W           = 32,
  parameter logic [PC_W-1:0]   PC_RESET       = 32'h8000_0000,
  parameter logic [CTRL_W-1:0] CTRL_KEEP_MASK = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [1:0]        occupancy
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [PC_W-1:0]   main_pc;

  logic              accept;
  logic              emit;
  logic [CTRL_W-1:0] in_ctrl_eff;

  assign accept      = in_valid & in_ready;
  assign emit        = main_valid & out_ready;
  // A bubble keeps only the masked control bits; data and pc travel untouched.
  assign in_ctrl_eff = bubble ? (in_ctrl & CTRL_KEEP_MASK) : in_ctrl;

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign out_pc    = main_pc;

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [PC_W-1:0]   skid_pc;

  // skid_valid is a flop, so in_ready has no path from out_ready.
  assign in_ready  = ~skid_valid;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      main_pc    <= PC_RESET;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (emit) begin
        main_ctrl  <= skid_ctrl;
        main_data  <= skid_data;
        main_pc    <= skid_pc;
        skid_valid <= 1'b0;
      end
    end else if (accept && (!main_valid || emit)) begin
      main_valid <= 1'b1;
      main_ctrl  <= in_ctrl_eff;
      main_data  <= in_data;
      main_pc    <= in_pc;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl_eff;
      skid_data  <= in_data;
      skid_pc    <= in_pc;
    end else if (emit) begin
      main_valid <= 1'b0;
    end
  end
`else
  assign in_ready  = ~main_valid | out_ready;
  assign occupancy = {1'b0, main_valid};

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      main_pc    <= PC_RESET;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (accept) begin
      main_valid <= 1'b1;
      main_ctrl  <= in_ctrl_eff;
      main_data  <= in_data;
      main_pc    <= in_pc;
    end else if (emit) begin
      main_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: queue model of held beats, driver pushes on accept, monitor pops on emit.
module tb_pipe_stage_reg;
  localparam int          CW   = 16;
  localparam int          DW   = 128;
  localparam int          PW   = 32;
  localparam logic [15:0] KEEP = 16'h0004;
  localparam logic [31:0] PCR  = 32'h8000_0000;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [PW-1:0] p;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0, in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic [PW-1:0] in_pc = '0;
  logic          bubble = 1'b0, flush = 1'b0;
  logic          out_valid, out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_pc;
  logic [1:0]    occupancy;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .PC_W(PW), .PC_RESET(PCR), .CTRL_KEEP_MASK(KEEP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_data(in_data), .in_pc(in_pc), .bubble(bubble), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data), .out_pc(out_pc),
    .occupancy(occupancy)
  );

  int        n_checks = 0;
  int        n_fail = 0;
  bit        mon_en = 1'b0;
  beat_t     q[$];
  logic [PW-1:0] last_pc = PCR;
  logic [DW-1:0] last_data = '0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic exp_in_ready(input logic ordy);
`ifdef PIPE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || ordy;
`endif
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One cycle: drive at negedge, check status #1 later, update the model after the edge.
  task automatic step(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic [PW-1:0] p, input logic bub, input logic fl,
                      input logic ordy, input logic rst, output logic acc);
    beat_t b;
    logic  eir;
    @(negedge clk);
    in_valid = iv; in_ctrl = c; in_data = d; in_pc = p;
    bubble = bub; flush = fl; out_ready = ordy; reset = rst;
    #1;
    eir = exp_in_ready(ordy);
    chk("in_ready", {127'd0, in_ready}, {127'd0, eir});
    chk("out_valid", {127'd0, out_valid}, {127'd0, q.size() != 0});
    chk("occupancy", {126'd0, occupancy}, 128'(q.size()));
    if (q.size() != 0) begin
      last_pc   = q[0].p;
      last_data = q[0].d;
    end else begin
      chk("idle_ctrl", {112'd0, out_ctrl}, '0);
      chk("idle_pc", {96'd0, out_pc}, {96'd0, last_pc});
      chk("idle_data", out_data, last_data);
    end
    acc = iv & eir;
    @(posedge clk);
    if (rst) begin
      q.delete();
      last_pc   = PCR;
      last_data = '0;
    end else if (fl) begin
      q.delete();
    end else if (acc) begin
      b.c = bub ? (c & KEEP) : c;
      b.d = d;
      b.p = p;
      q.push_back(b);
    end
  endtask

  task automatic send(input logic [CW-1:0] c, input logic [PW-1:0] p, input logic bub, input logic ordy);
    logic acc = 1'b0;
    logic [DW-1:0] d = rnd_data();
    for (int i = 0; i < 20 && !acc; i++) step(1'b1, c, d, p, bub, 1'b0, ordy, 1'b0, acc);
    if (!acc) chk("send_timeout", '0, 128'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0, ordy, 1'b0, acc);
  endtask

  // Monitor: pops the expected beat whenever the DUT completes an emit.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL emit_unexpected: got pc %0h expected no beat", out_pc);
        end else begin
          b = q.pop_front();
          chk("emit_ctrl", {112'd0, out_ctrl}, {112'd0, b.c});
          chk("emit_data", out_data, b.d);
          chk("emit_pc", {96'd0, out_pc}, {96'd0, b.p});
        end
      end
    end
  end

  initial begin
    logic acc;
    @(posedge clk);
    mon_en = 1'b1;
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);

    // Streaming after reset
    send(16'h1111, 32'h100, 1'b0, 1'b1);
    send(16'h2222, 32'h104, 1'b0, 1'b1);
    send(16'h3333, 32'h108, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Back-pressure
    step(1'b1, 16'h0A0A, rnd_data(), 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    acc = 1'b0;
    for (int i = 0; i < 3 && !acc; i++)
      step(1'b1, 16'h0B0B, 128'h204, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    idle(1, 1'b0);
    if (!acc) send(16'h0B0B, 32'h204, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Bubble keeps only the masked control bit
    send(16'hFFFF, 32'h300, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Flush with beats held and an incoming beat
    step(1'b1, 16'h4000, rnd_data(), 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 16'h4004, rnd_data(), 32'h404, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 16'h4008, rnd_data(), 32'h408, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    idle(1, 1'b0);
    send(16'h400C, 32'h40C, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Reset mid-flow with flush and incoming beat
    step(1'b1, 16'h5000, rnd_data(), 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 16'h5004, rnd_data(), 32'h504, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 16'h5008, rnd_data(), 32'h508, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    idle(3, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, 16'($urandom), rnd_data(), $urandom,
           $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 6, $urandom_range(0, 149) == 0, acc);
    end
    idle(4, 1'b1);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
